// File: rtl/ppe_pkg.sv
// ppe_pkg: shared defaults and mode encoding for the priority pick engine
package ppe_pkg;
  localparam int PPE_WIDTH = 1024;
  localparam int PPE_LOG_W = 10;
  typedef enum logic {
    PPE_FIXED = 1'b0,
    PPE_RR    = 1'b1
  } ppe_mode_e;
endpackage

// File: rtl/ppe_mask_gen.sv
// ppe_mask_gen: thermometer mask with bits [ptr_eff-1:0] set
module ppe_mask_gen import ppe_pkg::*; #(
  parameter int WIDTH = PPE_WIDTH,
  parameter int LOG_W = PPE_LOG_W
) (
  input  logic [LOG_W-1:0] ptr_eff,
  output logic [WIDTH-1:0] mask
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  assign mask = (ONE << ptr_eff) - ONE;
endmodule

// File: rtl/ppe_mask_stage.sv
// ppe_mask_stage: registers a request vector masked below the last grant for round-robin arbitration
module ppe_mask_stage import ppe_pkg::*; #(
  parameter int WIDTH = PPE_WIDTH,
  parameter int LOG_W = PPE_LOG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_req,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_vec,
  output logic             m_none,
  input  logic [LOG_W-1:0] enc_idx,
  input  logic             cfg_rr,
  input  logic             cfg_ptr_we,
  input  logic [LOG_W-1:0] cfg_ptr
);
  logic             m_valid_q, m_valid_d, m_none_q, m_none_d;
  logic [WIDTH-1:0] m_vec_q, m_vec_d, mask, masked;
  logic [LOG_W-1:0] ptr_q, ptr_d, ptr_eff;
  logic             accept, capture, rr;
  assign rr      = ppe_mode_e'(cfg_rr) == PPE_RR;
  assign s_ready = !m_valid_q || m_ready;
  assign accept  = m_valid_q && m_ready;
  assign capture = s_valid && s_ready;
  // a pointer load or an in-flight grant must steer the vector captured this same cycle
  assign ptr_eff = cfg_ptr_we ? cfg_ptr : accept ? enc_idx : ptr_q;
  assign masked  = s_req & mask;
  ppe_mask_gen #(.WIDTH(WIDTH), .LOG_W(LOG_W)) u_mask (
    .ptr_eff(ptr_eff),
    .mask   (mask)
  );
  always_comb begin
    m_valid_d = capture ? 1'b1 : accept ? 1'b0 : m_valid_q;
    m_vec_d   = capture ? ((rr && |masked) ? masked : s_req) : m_vec_q;
    m_none_d  = capture ? ~|s_req : m_none_q;
    ptr_d     = cfg_ptr_we ? cfg_ptr : (accept && !m_none_q && rr) ? enc_idx : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_vec_q   <= '0;
      m_none_q  <= 1'b0;
      ptr_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_vec_q   <= m_vec_d;
      m_none_q  <= m_none_d;
      ptr_q     <= ptr_d;
    end
  end
  assign m_valid = m_valid_q;
  assign m_vec   = m_vec_q;
  assign m_none  = m_none_q;
endmodule

// File: tb/tb_ppe_mask_stage.sv
// tb_ppe_mask_stage: directed vectors plus randomized run against a behavioural model
module tb_ppe_mask_stage;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b1, m_none;
  logic [7:0] s_req = '0, m_vec;
  logic [2:0] enc_idx, cfg_ptr = '0;
  logic       cfg_rr = 1'b1, cfg_ptr_we = 1'b0;
  int         total = 0, passed = 0;

  always #5 clk = ~clk;

  ppe_mask_stage #(.WIDTH(8), .LOG_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_req(s_req),
    .m_valid(m_valid), .m_ready(m_ready), .m_vec(m_vec), .m_none(m_none),
    .enc_idx(enc_idx), .cfg_rr(cfg_rr), .cfg_ptr_we(cfg_ptr_we), .cfg_ptr(cfg_ptr)
  );

  function automatic int hi(input int v);
    hi = 0;
    for (int i = 0; i < 8; i++) if (v & (1 << i)) hi = i;
  endfunction

  always_comb enc_idx = 3'(hi(int'(m_vec)));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] req;
    logic       rr, we;
    logic [2:0] cptr;
    logic [7:0] vec;
    logic       none;
  } vec_t;

  vec_t tbl[11];

  int ev, evec, enone, mptr;

  initial begin
    tbl[0]  = '{8'hA4, 1, 0, 0, 8'hA4, 0};
    tbl[1]  = '{8'hA4, 1, 0, 0, 8'h24, 0};
    tbl[2]  = '{8'hA4, 1, 0, 0, 8'h04, 0};
    tbl[3]  = '{8'hA4, 1, 0, 0, 8'hA4, 0};
    tbl[4]  = '{8'hA4, 1, 0, 0, 8'h24, 0};
    tbl[5]  = '{8'hFF, 1, 1, 4, 8'h0F, 0};
    tbl[6]  = '{8'hFF, 1, 0, 0, 8'h07, 0};
    tbl[7]  = '{8'h81, 0, 0, 0, 8'h81, 0};
    tbl[8]  = '{8'h81, 0, 0, 0, 8'h81, 0};
    tbl[9]  = '{8'h00, 1, 0, 0, 8'h00, 1};
    tbl[10] = '{8'hA4, 1, 0, 0, 8'hA4, 0};

    #12;
    chk("reset m_valid", m_valid, 0);
    chk("reset m_vec", m_vec, 0);
    chk("reset s_ready", s_ready, 1);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      s_valid = 1'b1; s_req = tbl[i].req; cfg_rr = tbl[i].rr;
      cfg_ptr_we = tbl[i].we; cfg_ptr = tbl[i].cptr;
      @(negedge clk);
      cfg_ptr_we = 1'b0;
      chk($sformatf("tbl[%0d] m_valid", i), m_valid, 1);
      chk($sformatf("tbl[%0d] m_vec", i), m_vec, tbl[i].vec);
      chk($sformatf("tbl[%0d] m_none", i), m_none, tbl[i].none);
    end

    m_ready = 1'b0; s_req = 8'h11; #1;
    chk("stall s_ready", s_ready, 0);
    @(negedge clk);
    chk("stall m_vec held", m_vec, 8'hA4);
    m_ready = 1'b1;
    @(negedge clk);
    chk("release m_vec", m_vec, 8'h11);

    s_valid = 1'b0; m_ready = 1'b0; #2;
    rst_n = 1'b0; #1;
    chk("async rst m_valid", m_valid, 0);
    chk("async rst m_vec", m_vec, 0);
    chk("async rst s_ready", s_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    s_valid = 1'b1; s_req = 8'hA4; m_ready = 1'b1;
    @(negedge clk);
    chk("post rst unmasked", m_vec, 8'hA4);
    s_req = 8'h00;
    @(negedge clk);
    chk("none m_none", m_none, 1);
    chk("none m_vec", m_vec, 0);
    s_valid = 1'b0;
    @(negedge clk);
    chk("drain m_valid", m_valid, 0);
    s_valid = 1'b1; s_req = 8'hA4;
    @(negedge clk);
    chk("ptr held over none", m_vec, 8'h24);

    s_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    ev = 0; evec = 0; enone = 0; mptr = 0;
    for (int c = 0; c < 400; c++) begin
      int acc, cap, enc, pe, m, rq;
      s_valid = 1'($urandom_range(0, 3) != 0);
      s_req = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      m_ready = 1'($urandom_range(0, 3) != 0);
      cfg_rr = 1'($urandom_range(0, 5) != 0);
      cfg_ptr_we = 1'($urandom_range(0, 9) == 0);
      cfg_ptr = 3'($urandom);
      #1;
      chk($sformatf("rnd[%0d] s_ready", c), s_ready, (!ev || m_ready) ? 1 : 0);
      rq = int'(s_req);
      acc = (ev && m_ready) ? 1 : 0;
      cap = (s_valid && (!ev || m_ready)) ? 1 : 0;
      enc = hi(evec);
      pe = cfg_ptr_we ? int'(cfg_ptr) : acc ? enc : mptr;
      m = rq & ((1 << pe) - 1);
      if (cfg_ptr_we) mptr = int'(cfg_ptr);
      else if (acc && !enone && cfg_rr) mptr = enc;
      if (cap) begin
        ev = 1; evec = (cfg_rr && m != 0) ? m : rq; enone = (rq == 0) ? 1 : 0;
      end else if (acc) ev = 0;
      @(negedge clk);
      chk($sformatf("rnd[%0d] m_valid", c), m_valid, ev);
      if (ev) begin
        chk($sformatf("rnd[%0d] m_vec", c), m_vec, evec);
        chk($sformatf("rnd[%0d] m_none", c), m_none, enone);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
